// File: rtl/dram_timing_ctrl_mb.sv
// rtl/dram_timing_ctrl_mb.sv - multi-bank DRAM timing window tracker and done-qualifier source
// Optional DRAM_TIMING_VIOL_CHK_EN adds a sticky timing_viol output flagging commands issued early.
module dram_timing_ctrl_mb #(
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = 8,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 10,
  parameter int T_WR      = 4,
  parameter int T_WTR     = 3,
  parameter int T_RFC     = 30,
  parameter int T_REFI    = 1560,
  parameter int REFI_W    = 12,
  parameter int BURST_LEN = 4,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic [BANK_W-1:0]    cmd_bank,
  output logic [NUM_BANKS-1:0] tACT_done,
  output logic [NUM_BANKS-1:0] tPRE_done,
  output logic [NUM_BANKS-1:0] tRAS_done,
  output logic [NUM_BANKS-1:0] tWR_done,
  output logic                 tRD_done,
  output logic                 tWRITE_done,
  output logic                 tWTR_done,
  output logic                 tREF_done,
  output logic                 rf_req,
  output logic                 rd_en,
  output logic                 wr_en,
`ifdef DRAM_TIMING_VIOL_CHK_EN
  output logic                 timing_viol,
`endif
  output logic                 clear
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  if (T_RCD > CNT_MAX || T_RP > CNT_MAX || T_RAS > CNT_MAX || T_RFC > CNT_MAX ||
      BURST_LEN + T_WR > CNT_MAX || BURST_LEN + T_WTR > CNT_MAX) begin : g_cnt_overflow
    $error("dram_timing_ctrl_mb: a timing value does not fit CNT_W");
  end
  if (T_REFI > (64'd1 << REFI_W)) begin : g_refi_overflow
    $error("dram_timing_ctrl_mb: T_REFI does not fit REFI_W");
  end

  // Windows hold cycles-remaining-until-done, so done rises exactly T cycles after the command.
  localparam logic [CNT_W-1:0]  L_RCD   = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0]  L_RP    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0]  L_RAS   = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0]  L_WRR   = CNT_W'(BURST_LEN + T_WR - 1);
  localparam logic [CNT_W-1:0]  L_WTR   = CNT_W'(BURST_LEN + T_WTR - 1);
  localparam logic [CNT_W-1:0]  L_RFC   = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0]  L_BURST = CNT_W'(BURST_LEN);
  localparam logic [REFI_W-1:0] L_REFI  = REFI_W'(T_REFI - 1);

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic is_act, is_rd, is_wr, is_pre, is_ref;
  assign is_act = cmd_valid && (cmd_type == 3'd1);
  assign is_rd  = cmd_valid && (cmd_type == 3'd2);
  assign is_wr  = cmd_valid && (cmd_type == 3'd3);
  assign is_pre = cmd_valid && (cmd_type == 3'd4);
  assign is_ref = cmd_valid && (cmd_type == 3'd5);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [CNT_W-1:0] rcd, rp, ras, wrr;
    logic             hit;
    assign hit = (cmd_bank == BANK_W'(g));

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        rcd <= '0;
        rp  <= '0;
        ras <= '0;
        wrr <= '0;
      end else begin
        rcd <= (is_act && hit) ? L_RCD : dec(rcd);
        ras <= (is_act && hit) ? L_RAS : dec(ras);
        rp  <= (is_pre && hit) ? L_RP  : dec(rp);
        wrr <= (is_wr  && hit) ? L_WRR : dec(wrr);
      end
    end

    assign tACT_done[g] = (rcd == '0);
    assign tPRE_done[g] = (rp  == '0);
    assign tRAS_done[g] = (ras == '0);
    assign tWR_done[g]  = (wrr == '0);
  end

  logic [CNT_W-1:0]  rd_burst, wr_burst, wtr, rfc;
  logic [REFI_W-1:0] refi;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_burst <= '0;
      wr_burst <= '0;
      wtr      <= '0;
      rfc      <= '0;
      refi     <= '0;
      rf_req   <= 1'b0;
      clear    <= 1'b0;
    end else begin
      rd_burst <= is_rd  ? L_BURST : dec(rd_burst);
      wr_burst <= is_wr  ? L_BURST : dec(wr_burst);
      wtr      <= is_wr  ? L_WTR   : dec(wtr);
      rfc      <= is_ref ? L_RFC   : dec(rfc);
      // A reload on the last beat extends the window, so no end-of-burst pulse.
      clear    <= (rd_burst == CNT_W'(1) && !is_rd) || (wr_burst == CNT_W'(1) && !is_wr);
      if (is_ref) begin
        refi   <= '0;
        rf_req <= 1'b0;
      end else if (refi == L_REFI) begin
        refi   <= '0;
        rf_req <= 1'b1;
      end else begin
        refi   <= refi + 1'b1;
      end
    end
  end

  assign rd_en       = (rd_burst != '0);
  assign wr_en       = (wr_burst != '0);
  assign tRD_done    = !rd_en;
  assign tWRITE_done = !wr_en;
  assign tWTR_done   = (wtr == '0);
  assign tREF_done   = (rfc == '0);

`ifdef DRAM_TIMING_VIOL_CHK_EN
  logic viol_now;
  assign viol_now = ((is_act || is_rd || is_wr || is_pre || is_ref) && !tREF_done) ||
                    (is_act && !tPRE_done[cmd_bank]) ||
                    ((is_rd || is_wr) && !tACT_done[cmd_bank]) ||
                    (is_rd && !tWTR_done) ||
                    (is_pre && (!tRAS_done[cmd_bank] || !tWR_done[cmd_bank]));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timing_viol <= 1'b0;
    end else if (viol_now) begin
      timing_viol <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_timing_ctrl_mb.sv
// tb/tb_dram_timing_ctrl_mb.sv - table-driven scoreboard bench for dram_timing_ctrl_mb
// Build with DRAM_TIMING_VIOL_CHK_EN to include the timing_viol sequence.
module tb_dram_timing_ctrl_mb;
  localparam logic [2:0]  C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;
  localparam logic [15:0] B_IDLE = 16'hFFFF;
  // {tRD_done, tWRITE_done, tWTR_done, tREF_done, rd_en, wr_en, clear}
  localparam logic [6:0]  G_IDLE = 7'b1111000;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_type = 3'd0;
  logic [1:0] cmd_bank = 2'd0;
  logic [3:0] tACT_done, tPRE_done, tRAS_done, tWR_done;
  logic       tRD_done, tWRITE_done, tWTR_done, tREF_done, rf_req, rd_en, wr_en, clear;
`ifdef DRAM_TIMING_VIOL_CHK_EN
  logic       timing_viol;
`endif

  dram_timing_ctrl_mb dut (
    .CLK(CLK), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
    .tACT_done(tACT_done), .tPRE_done(tPRE_done), .tRAS_done(tRAS_done), .tWR_done(tWR_done),
    .tRD_done(tRD_done), .tWRITE_done(tWRITE_done), .tWTR_done(tWTR_done), .tREF_done(tREF_done),
    .rf_req(rf_req), .rd_en(rd_en), .wr_en(wr_en),
`ifdef DRAM_TIMING_VIOL_CHK_EN
    .timing_viol(timing_viol),
`endif
    .clear(clear)
  );

  always #5 CLK = ~CLK;

  logic [15:0] bank_obs;
  logic [6:0]  glob_obs;
  assign bank_obs = {tACT_done, tPRE_done, tRAS_done, tWR_done};
  assign glob_obs = {tRD_done, tWRITE_done, tWTR_done, tREF_done, rd_en, wr_en, clear};

  typedef struct {
    string       name;
    logic        v;
    logic [2:0]  t;
    logic [1:0]  b;
    logic [15:0] bank_exp;
    logic [6:0]  glob_exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic v, input logic [2:0] t, input logic [1:0] b,
                     input logic [15:0] be, input logic [6:0] ge);
    vec_t r;
    r.name = n; r.v = v; r.t = t; r.b = b; r.bank_exp = be; r.glob_exp = ge;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [1:0] b);
    cmd_valid = v;
    cmd_type  = t;
    cmd_bank  = b;
  endtask

  task automatic do_reset();
    drive(1'b0, C_NOP, 2'd0);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
  endtask

  int n, m, early;

  initial begin
    // Each row: command driven this cycle, outputs expected the following cycle.
    add("idle", 0, C_NOP, 0, B_IDLE, G_IDLE);
    add("act2", 1, C_ACT, 2, 16'hBFBF, G_IDLE);
    for (int i = 0; i < 2; i++) add("act2_rcd", 0, C_NOP, 0, 16'hBFBF, G_IDLE);
    for (int i = 0; i < 6; i++) add("act2_ras", 0, C_NOP, 0, 16'hFFBF, G_IDLE);
    add("act2_ras_end", 0, C_NOP, 0, B_IDLE, G_IDLE);
    add("wr1", 1, C_WR, 1, 16'hFFFD, 7'b1001010);
    for (int i = 0; i < 3; i++) add("wr1_burst", 0, C_NOP, 0, 16'hFFFD, 7'b1001010);
    add("wr1_clear", 0, C_NOP, 0, 16'hFFFD, 7'b1101001);
    add("wr1_wtr", 0, C_NOP, 0, 16'hFFFD, 7'b1101000);
    add("wr1_wtr_end", 0, C_NOP, 0, 16'hFFFD, G_IDLE);
    add("wr1_wrr_end", 0, C_NOP, 0, B_IDLE, G_IDLE);
    add("rd_a", 1, C_RD, 0, B_IDLE, 7'b0111100);
    add("rd_a_beat", 0, C_NOP, 0, B_IDLE, 7'b0111100);
    add("rd_b_restart", 1, C_RD, 0, B_IDLE, 7'b0111100);
    for (int i = 0; i < 3; i++) add("rd_b_beat", 0, C_NOP, 0, B_IDLE, 7'b0111100);
    add("rd_clear", 0, C_NOP, 0, B_IDLE, 7'b1111001);
    add("rd_idle", 0, C_NOP, 0, B_IDLE, G_IDLE);
    add("pre3", 1, C_PRE, 3, 16'hF7FF, G_IDLE);
    for (int i = 0; i < 2; i++) add("pre3_rp", 0, C_NOP, 0, 16'hF7FF, G_IDLE);
    add("pre3_rp_end", 0, C_NOP, 0, B_IDLE, G_IDLE);
    add("act_not_valid", 0, C_ACT, 0, B_IDLE, G_IDLE);
    add("type7_as_nop", 1, 3'd7, 0, B_IDLE, G_IDLE);
    add("type0_nop", 1, C_NOP, 1, B_IDLE, G_IDLE);

    do_reset();
    check("reset_bank_done", bank_obs, B_IDLE);
    check("reset_glob", glob_obs, G_IDLE);
    check("reset_rf_req", rf_req, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].t, vecs[i].b);
      sb.push_back(vecs[i]);
      @(negedge CLK);
      begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("%s[%0d].bank", e.name, i), bank_obs, e.bank_exp);
        check($sformatf("%s[%0d].glob", e.name, i), glob_obs, e.glob_exp);
      end
    end
    drive(1'b0, C_NOP, 2'd0);

    // Asynchronous reset in the middle of open windows.
    do_reset();
    drive(1'b1, C_ACT, 2'd0);
    @(negedge CLK);
    drive(1'b1, C_WR, 2'd0);
    @(negedge CLK);
    drive(1'b0, C_NOP, 2'd0);
    check("midop_act_open", tACT_done[0], 0);
    check("midop_wr_en", wr_en, 1);
    #2 nRST = 1'b0;
    #1;
    check("midop_reset_bank", bank_obs, B_IDLE);
    check("midop_reset_glob", glob_obs, G_IDLE);
    @(negedge CLK);
    nRST = 1'b1;

`ifdef DRAM_TIMING_VIOL_CHK_EN
    do_reset();
    drive(1'b1, C_ACT, 2'd0);
    @(negedge CLK);
    drive(1'b0, C_NOP, 2'd0);
    @(negedge CLK);
    check("viol_before", timing_viol, 0);
    drive(1'b1, C_PRE, 2'd0);
    @(negedge CLK);
    drive(1'b0, C_NOP, 2'd0);
    check("viol_set", timing_viol, 1);
    repeat (5) @(negedge CLK);
    check("viol_sticky", timing_viol, 1);
    nRST = 1'b0;
    #1;
    check("viol_reset", timing_viol, 0);
    @(negedge CLK);
    nRST = 1'b1;
`endif

    // Refresh interval, REF timing and REF coinciding with the interval wrap.
    do_reset();
    n = 0;
    while (!rf_req && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rf_req_first_rise", n, 1560);
    repeat (3) @(negedge CLK);
    check("rf_req_sticky", rf_req, 1);
    drive(1'b1, C_REF, 2'd0);
    @(negedge CLK);
    drive(1'b0, C_NOP, 2'd0);
    check("rf_req_cleared_by_ref", rf_req, 0);
    check("tref_done_low", tREF_done, 0);
    m = 1;
    while (!tREF_done && m < 100) begin
      @(negedge CLK);
      m++;
    end
    check("tref_done_rise", m, 30);
    early = 0;
    while (m < 1560) begin
      @(negedge CLK);
      m++;
      if (rf_req) early++;
    end
    check("rf_req_quiet_before_wrap", early, 0);
    drive(1'b1, C_REF, 2'd0);
    @(negedge CLK);
    drive(1'b0, C_NOP, 2'd0);
    check("rf_req_ref_on_wrap", rf_req, 0);
    n = 1;
    while (!rf_req && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("rf_req_after_ref_on_wrap", n, 1561);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
